// File: rtl/alu_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_sequencer_pkg
// Description : ALU op codes, sequencer function codes, FSM states and
//               micro-step table types. Macro ALU_SEQUENCER_SLT_EN adds SLT.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_sequencer_pkg;

    typedef enum logic [3:0] {
        ALU_OP_A    = 4'd0,
        ALU_OP_ADD  = 4'd1,
        ALU_OP_AND  = 4'd2,
        ALU_OP_OR   = 4'd3,
        ALU_OP_XOR  = 4'd4,
        ALU_OP_NOTA = 4'd5,
        ALU_OP_INC  = 4'd6,
        ALU_OP_SHL  = 4'd7,
        ALU_OP_SHR  = 4'd8,
        ALU_OP_GT   = 4'd9,
        ALU_OP_EQ   = 4'd10
    } alu_op_e;

    typedef enum logic [3:0] {
        FUNC_ADD  = 4'd0,
        FUNC_SUB  = 4'd1,
        FUNC_AND  = 4'd2,
        FUNC_OR   = 4'd3,
        FUNC_XOR  = 4'd4,
        FUNC_SLL  = 4'd5,
        FUNC_SRL  = 4'd6,
        FUNC_SLTU = 4'd7,
        FUNC_SLT  = 4'd8,
        FUNC_EQ   = 4'd9
    } func_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        SRC_ZERO    = 3'd0,
        SRC_A       = 3'd1,
        SRC_B       = 3'd2,
        SRC_T       = 3'd3,
        SRC_SHMASK  = 3'd4,
        SRC_ONE     = 3'd5
`ifdef ALU_SEQUENCER_SLT_EN
        ,SRC_SIGN   = 3'd6
`endif
    } src_e;

`ifdef ALU_SEQUENCER_SLT_EN
    typedef enum logic [1:0] {
        DST_T = 2'd0,
        DST_A = 2'd1,
        DST_B = 2'd2
    } dst_e;
`endif

    typedef struct packed {
        alu_op_e op;
        src_e    src0;
        src_e    src1;
`ifdef ALU_SEQUENCER_SLT_EN
        dst_e    dst;
`endif
        logic    last;
    } step_t;

    localparam int c_step_w = 2;

    function automatic logic func_legal(input logic [3:0] f);
`ifdef ALU_SEQUENCER_SLT_EN
        return (f <= FUNC_EQ);
`else
        return (f <= FUNC_EQ) && (f != FUNC_SLT);
`endif
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module      : alu
// Description : Combinational ALU driven by the sequencer operand/op ports.
// Revision    : 1.0 - initial release
// ============================================================================
module alu
    import alu_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = 32
)
(
    input  logic [3:0]            i_op,
    input  logic [DATA_WIDTH-1:0] i_data0,
    input  logic [DATA_WIDTH-1:0] i_data1,
    output logic [DATA_WIDTH-1:0] o_data
);
    localparam int c_shw = $clog2(DATA_WIDTH);

    // Shifts move operand B by the amount in operand A.
    always_comb begin
        o_data = '0;
        case (i_op)
            ALU_OP_A:    o_data = i_data0;
            ALU_OP_ADD:  o_data = i_data0 + i_data1;
            ALU_OP_AND:  o_data = i_data0 & i_data1;
            ALU_OP_OR:   o_data = i_data0 | i_data1;
            ALU_OP_XOR:  o_data = i_data0 ^ i_data1;
            ALU_OP_NOTA: o_data = ~i_data0;
            ALU_OP_INC:  o_data = i_data0 + DATA_WIDTH'(1);
            ALU_OP_SHL:  o_data = i_data1 << i_data0[c_shw-1:0];
            ALU_OP_SHR:  o_data = i_data1 >> i_data0[c_shw-1:0];
            ALU_OP_GT:   o_data = DATA_WIDTH'(i_data0 > i_data1);
            ALU_OP_EQ:   o_data = DATA_WIDTH'(i_data0 == i_data1);
            default:     o_data = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_sequencer_rom.sv
`default_nettype none
// ============================================================================
// Module      : alu_sequencer_rom
// Description : Combinational step table: (func, step) -> op, sources, last.
//               SLT entries exist only with ALU_SEQUENCER_SLT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer_rom
    import alu_sequencer_pkg::*;
(
    input  logic [3:0]          i_func,
    input  logic [c_step_w-1:0] i_step,
    output step_t               o_entry
);
    function automatic step_t ent(input alu_op_e op, input src_e s0,
                                  input src_e s1, input logic last);
        step_t e;
        e.op   = op;
        e.src0 = s0;
        e.src1 = s1;
`ifdef ALU_SEQUENCER_SLT_EN
        e.dst  = DST_T;
`endif
        e.last = last;
        return e;
    endfunction

    always_comb begin
        o_entry = ent(ALU_OP_A, SRC_ZERO, SRC_ZERO, 1'b1);
        case (i_func)
            FUNC_ADD: o_entry = ent(ALU_OP_ADD, SRC_A, SRC_B, 1'b1);
            FUNC_AND: o_entry = ent(ALU_OP_AND, SRC_A, SRC_B, 1'b1);
            FUNC_OR:  o_entry = ent(ALU_OP_OR,  SRC_A, SRC_B, 1'b1);
            FUNC_XOR: o_entry = ent(ALU_OP_XOR, SRC_A, SRC_B, 1'b1);
            FUNC_SUB: begin
                if (i_step == '0)
                    o_entry = ent(ALU_OP_NOTA, SRC_B, SRC_ZERO, 1'b0);
                else if (i_step == c_step_w'(1))
                    o_entry = ent(ALU_OP_INC, SRC_T, SRC_ZERO, 1'b0);
                else
                    o_entry = ent(ALU_OP_ADD, SRC_A, SRC_T, 1'b1);
            end
            FUNC_SLL: begin
                if (i_step == '0)
                    o_entry = ent(ALU_OP_AND, SRC_B, SRC_SHMASK, 1'b0);
                else
                    o_entry = ent(ALU_OP_SHL, SRC_T, SRC_A, 1'b1);
            end
            FUNC_SRL: begin
                if (i_step == '0)
                    o_entry = ent(ALU_OP_AND, SRC_B, SRC_SHMASK, 1'b0);
                else
                    o_entry = ent(ALU_OP_SHR, SRC_T, SRC_A, 1'b1);
            end
            FUNC_SLTU: begin
                if (i_step == '0)
                    o_entry = ent(ALU_OP_GT, SRC_B, SRC_A, 1'b0);
                else
                    o_entry = ent(ALU_OP_AND, SRC_T, SRC_ONE, 1'b1);
            end
            FUNC_EQ: begin
                if (i_step == '0)
                    o_entry = ent(ALU_OP_EQ, SRC_A, SRC_B, 1'b0);
                else
                    o_entry = ent(ALU_OP_AND, SRC_T, SRC_ONE, 1'b1);
            end
`ifdef ALU_SEQUENCER_SLT_EN
            // Flipping the sign bits turns the signed compare into an unsigned one.
            FUNC_SLT: begin
                if (i_step == '0) begin
                    o_entry     = ent(ALU_OP_XOR, SRC_A, SRC_SIGN, 1'b0);
                    o_entry.dst = DST_A;
                end else if (i_step == c_step_w'(1)) begin
                    o_entry     = ent(ALU_OP_XOR, SRC_B, SRC_SIGN, 1'b0);
                    o_entry.dst = DST_B;
                end else if (i_step == c_step_w'(2)) begin
                    o_entry = ent(ALU_OP_GT, SRC_B, SRC_A, 1'b0);
                end else begin
                    o_entry = ent(ALU_OP_AND, SRC_T, SRC_ONE, 1'b1);
                end
            end
`endif
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_sequencer
// Description : Multi-cycle function sequencer driving an external ALU one
//               micro-step per cycle. Macro ALU_SEQUENCER_SLT_EN enables SLT.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = 32
)
(
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [3:0]            i_func,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_result,
    output logic                  o_error,
    output logic [DATA_WIDTH-1:0] o_alu_data0,
    output logic [DATA_WIDTH-1:0] o_alu_data1,
    output logic [3:0]            o_alu_op,
    input  logic [DATA_WIDTH-1:0] i_alu_data
);
    localparam logic [DATA_WIDTH-1:0] c_shift_mask = DATA_WIDTH'(DATA_WIDTH - 1);
`ifdef ALU_SEQUENCER_SLT_EN
    localparam logic [DATA_WIDTH-1:0] c_sign_mask = {1'b1, {(DATA_WIDTH-1){1'b0}}};
`endif

    state_e                state_q, state_d;
    logic [3:0]            func_q, func_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [DATA_WIDTH-1:0] t_q, t_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  error_q, error_d;
    logic [c_step_w-1:0]   step_q, step_d;
    step_t                 w_rom_entry;

    alu_sequencer_rom u_rom (
        .i_func  (func_q),
        .i_step  (step_q),
        .o_entry (w_rom_entry)
    );

    function automatic logic [DATA_WIDTH-1:0] pick(input src_e s,
                                                   input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b,
                                                   input logic [DATA_WIDTH-1:0] t);
        logic [DATA_WIDTH-1:0] v;
        v = '0;
        case (s)
            SRC_A:      v = a;
            SRC_B:      v = b;
            SRC_T:      v = t;
            SRC_SHMASK: v = c_shift_mask;
            SRC_ONE:    v = DATA_WIDTH'(1);
`ifdef ALU_SEQUENCER_SLT_EN
            SRC_SIGN:   v = c_sign_mask;
`endif
            default:    v = '0;
        endcase
        return v;
    endfunction

    assign o_ready  = (state_q == ST_IDLE);
    assign o_valid  = (state_q == ST_DONE);
    assign o_result = result_q;
    assign o_error  = error_q;

    // ALU operands come only from registers, so each step is a clean one-cycle path.
    always_comb begin
        o_alu_op    = ALU_OP_A;
        o_alu_data0 = '0;
        o_alu_data1 = '0;
        if (state_q == ST_EXEC) begin
            o_alu_op    = w_rom_entry.op;
            o_alu_data0 = pick(w_rom_entry.src0, a_q, b_q, t_q);
            o_alu_data1 = pick(w_rom_entry.src1, a_q, b_q, t_q);
        end
    end

    always_comb begin
        state_d  = state_q;
        func_d   = func_q;
        a_d      = a_q;
        b_d      = b_q;
        t_d      = t_q;
        step_d   = step_q;
        result_d = result_q;
        error_d  = error_q;
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    func_d = i_func;
                    a_d    = i_a;
                    b_d    = i_b;
                    step_d = '0;
                    if (func_legal(i_func)) begin
                        state_d = ST_EXEC;
                    end else begin
                        state_d  = ST_DONE;
                        error_d  = 1'b1;
                        result_d = '0;
                    end
                end
            end
            ST_EXEC: begin
`ifdef ALU_SEQUENCER_SLT_EN
                case (w_rom_entry.dst)
                    DST_A:   a_d = i_alu_data;
                    DST_B:   b_d = i_alu_data;
                    default: t_d = i_alu_data;
                endcase
`else
                t_d = i_alu_data;
`endif
                step_d = step_q + 1'b1;
                if (w_rom_entry.last) begin
                    state_d  = ST_DONE;
                    result_d = i_alu_data;
                    error_d  = 1'b0;
                end
            end
            ST_DONE: begin
                if (i_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            func_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            t_q      <= '0;
            step_q   <= '0;
            result_q <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            func_q   <= func_d;
            a_q      <= a_d;
            b_q      <= b_d;
            t_q      <= t_d;
            step_q   <= step_d;
            result_q <= result_d;
            error_q  <= error_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_sequencer
// Description : Scoreboard bench for alu_sequencer with the real alu attached.
//               SLT expectations follow ALU_SEQUENCER_SLT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;
    import alu_sequencer_pkg::*;

    logic        clk;
    logic        rst;
    logic        i_valid;
    logic        o_ready;
    logic [3:0]  i_func;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_result;
    logic        o_error;
    logic [31:0] w_alu_d0;
    logic [31:0] w_alu_d1;
    logic [3:0]  w_alu_op;
    logic [31:0] w_alu_res;

    typedef struct {
        logic [31:0] res;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_sequencer #(.DATA_WIDTH(32)) dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_func      (i_func),
        .i_a         (i_a),
        .i_b         (i_b),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_result    (o_result),
        .o_error     (o_error),
        .o_alu_data0 (w_alu_d0),
        .o_alu_data1 (w_alu_d1),
        .o_alu_op    (w_alu_op),
        .i_alu_data  (w_alu_res)
    );

    alu #(.DATA_WIDTH(32)) u_alu (
        .i_op    (w_alu_op),
        .i_data0 (w_alu_d0),
        .i_data1 (w_alu_d1),
        .o_data  (w_alu_res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference behaviour: {error, result} and accept-to-valid latency.
    function automatic logic [32:0] model(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            4'd0: return {1'b0, a + b};
            4'd1: return {1'b0, a - b};
            4'd2: return {1'b0, a & b};
            4'd3: return {1'b0, a | b};
            4'd4: return {1'b0, a ^ b};
            4'd5: return {1'b0, a << b[4:0]};
            4'd6: return {1'b0, a >> b[4:0]};
            4'd7: return {1'b0, 31'd0, (a < b)};
`ifdef ALU_SEQUENCER_SLT_EN
            4'd8: return {1'b0, 31'd0, ($signed(a) < $signed(b))};
`endif
            4'd9: return {1'b0, 31'd0, (a == b)};
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    function automatic int model_lat(input logic [3:0] f);
        case (f)
            4'd0, 4'd2, 4'd3, 4'd4:  return 2;
            4'd1:                    return 4;
            4'd5, 4'd6, 4'd7, 4'd9:  return 3;
`ifdef ALU_SEQUENCER_SLT_EN
            4'd8:                    return 5;
`endif
            default:                 return 1;
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [3:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input logic exp_err,
                          input int exp_lat, input int stall);
        exp_t e;
        int   lat;
        e.res = exp_res;
        e.err = exp_err;
        e.lat = exp_lat;
        sb_q.push_back(e);
        @(negedge clk);
        check_value({tag, "_ready"}, 64'(o_ready), 64'd1);
        i_valid = 1'b1;
        i_func  = f;
        i_a     = a;
        i_b     = b;
        @(negedge clk);
        i_valid = 1'b0;
        i_func  = 4'hF;
        i_a     = 32'hDEAD_BEEF;
        i_b     = 32'hCAFE_F00D;
        lat = 1;
        while (!o_valid && lat < 16) begin
            @(negedge clk);
            lat++;
        end
        check_value({tag, "_valid"}, 64'(o_valid), 64'd1);
        if (sb_q.size() == 0) begin
            check_value({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            check_value({tag, "_result"}, 64'(o_result), 64'(e.res));
            check_value({tag, "_error"}, 64'(o_error), 64'(e.err));
            check_value({tag, "_latency"}, 64'(lat), 64'(e.lat));
            check_value({tag, "_aluop_idle"}, {w_alu_op, w_alu_d0, w_alu_d1}, 64'd0);
        end
        for (int i = 0; i < stall; i++) begin
            i_valid = 1'b1;
            i_func  = 4'd0;
            i_a     = $urandom;
            i_b     = $urandom;
            @(negedge clk);
            check_value({tag, "_stall_hold"}, {o_valid, o_ready, o_error, o_result},
                        {1'b1, 1'b0, e.err, e.res});
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
        check_value({tag, "_released"}, {o_valid, o_ready}, 64'b01);
    endtask

    initial begin
        logic [32:0] m;
        logic [3:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        int          seen;

        rst     = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_func  = '0;
        i_a     = '0;
        i_b     = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_value("reset_state", {o_ready, o_valid, o_error, o_result}, {1'b1, 1'b0, 1'b0, 32'd0});
        check_value("reset_alu_ports", {w_alu_op, w_alu_d0, w_alu_d1}, 64'd0);

        run_op("sub", 4'd1, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 4, 0);
        run_op("illegal_c", 4'hC, 32'd3, 32'd3, 32'd0, 1'b1, 1, 0);
        run_op("sll", 4'd5, 32'd1, 32'h25, 32'h20, 1'b0, 3, 0);
        run_op("srl", 4'd6, 32'h8000_0000, 32'd31, 32'd1, 1'b0, 3, 0);
`ifdef ALU_SEQUENCER_SLT_EN
        run_op("slt", 4'd8, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 5, 0);
`else
        run_op("slt_disabled", 4'd8, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1, 0);
`endif
        run_op("sltu", 4'd7, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 3, 0);
        run_op("add_stall", 4'd0, 32'd3, 32'd4, 32'd7, 1'b0, 2, 10);

        // Abort a SUB during its second step; nothing may come out.
        @(negedge clk);
        i_valid = 1'b1;
        i_func  = 4'd1;
        i_a     = 32'd5;
        i_b     = 32'd7;
        @(negedge clk);
        i_valid = 1'b0;
        @(negedge clk);
        check_value("abort_step1_op", 64'(w_alu_op), 64'(ALU_OP_INC));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_value("abort_state", {o_ready, o_valid, o_error, o_result}, {1'b1, 1'b0, 1'b0, 32'd0});
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (o_valid) seen++;
        end
        check_value("abort_no_response", 64'(seen), 64'd0);
        run_op("eq_after_abort", 4'd9, 32'd9, 32'd9, 32'd1, 1'b0, 3, 0);

        for (int i = 0; i < 16; i++) begin
            f = 4'($urandom_range(0, 11));
            a = $urandom;
            b = (i % 4 == 0) ? a : $urandom;
            m = model(f, a, b);
            run_op("rand", f, a, b, m[31:0], m[32], model_lat(f), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
